// File: rtl/pio_v2_pkg.sv
// Shared definitions for the second-generation edge-capture PIO:
// register word indices and the system bus width.
package pio_v2_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd7;

endpackage

// File: rtl/pio_in_filter.sv
// Input conditioning for the PIO pins: a metastability synchroniser
// followed either by a plain register or by a two-sample debounce
// filter clocked from a free-running prescaler.
module pio_in_filter
    import pio_v2_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_DIV = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] filt
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out_s;
    logic [WIDTH-1:0] filt_r;

    // Synchroniser chain: asynchronous pins enter at stage 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_DIV == 0) begin : g_direct
            // No debounce: the filtered value follows the synchroniser.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_r <= '0;
                end else begin
                    filt_r <= sync_out_s;
                end
            end
        end else begin : g_debounce
            localparam int PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

            logic [PW-1:0]    presc_r;
            logic [WIDTH-1:0] samp_r;
            logic [WIDTH-1:0] agree_s;
            logic             tick_s;

            assign tick_s  = (presc_r == PW'(DEBOUNCE_DIV - 1));
            // A bit is accepted only when two consecutive ticks saw the same level.
            assign agree_s = ~(sync_out_s ^ samp_r);

            // Prescaler: wraps after DEBOUNCE_DIV cycles, producing one tick.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    presc_r <= '0;
                end else if (tick_s) begin
                    presc_r <= '0;
                end else begin
                    presc_r <= presc_r + PW'(1);
                end
            end

            // Debounce: sample on each tick, update filt only on agreeing bits.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    samp_r <= '0;
                    filt_r <= '0;
                end else if (tick_s) begin
                    samp_r <= sync_out_s;
                    filt_r <= (sync_out_s & agree_s) | (filt_r & ~agree_s);
                end
            end
        end
    endgenerate

    assign filt = filt_r;

endmodule

// File: rtl/pio_edge_irq_v2.sv
// Avalon-MM general-purpose I/O port with per-bit direction, selectable
// rising/falling edge capture (write-1-to-clear) and a level interrupt.
module pio_edge_irq_v2
    import pio_v2_pkg::*;
#(
    parameter int          WIDTH        = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter int          DEBOUNCE_DIV = 0,
    parameter logic [31:0] RESET_OUT    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en
);

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] rd_field_s;
    logic [DATA_W-1:0] rd_mux_s;
    logic             unused_s;

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [WIDTH-1:0] filt_d_r;
    logic [WIDTH-1:0] cap_r;

    assign wr_s     = chipselect & ~write_n;
    assign wd_s     = writedata[WIDTH-1:0];
    // Write bits above WIDTH have no register behind them.
    assign unused_s = ^writedata;

    pio_in_filter #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_in_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .filt    (filt_s)
    );

    // Software-visible control registers and the output data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r     <= RESET_OUT[WIDTH-1:0];
            dir_r     <= '0;
            mask_r    <= '0;
            rise_en_r <= '1;
            fall_en_r <= '1;
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:      out_r     <= wd_s;
                ADDR_DIRECTION: dir_r     <= wd_s;
                ADDR_IRQ_MASK:  mask_r    <= wd_s;
                ADDR_OUTSET:    out_r     <= out_r | wd_s;
                ADDR_OUTCLEAR:  out_r     <= out_r & ~wd_s;
                ADDR_RISE_EN:   rise_en_r <= wd_s;
                ADDR_FALL_EN:   fall_en_r <= wd_s;
                default:        ;
            endcase
        end
    end

    assign edge_s = (filt_s & ~filt_d_r & rise_en_r) | (~filt_s & filt_d_r & fall_en_r);

    // Clear mask from a write-1-to-clear access to the capture register.
    always_comb begin
        clr_s = '0;
        if (wr_s && (address == ADDR_EDGE_CAPTURE)) begin
            clr_s = wd_s;
        end else begin
            clr_s = '0;
        end
    end

    // Edge history and capture; a new edge overrides a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d_r <= '0;
            cap_r    <= '0;
        end else begin
            filt_d_r <= filt_s;
            cap_r    <= edge_s | (cap_r & ~clr_s);
        end
    end

    // Read mux: selects the addressed register, zero-extended to the bus.
    always_comb begin
        rd_field_s = '0;
        case (address)
            ADDR_DATA:         rd_field_s = filt_s;
            ADDR_DIRECTION:    rd_field_s = dir_r;
            ADDR_IRQ_MASK:     rd_field_s = mask_r;
            ADDR_EDGE_CAPTURE: rd_field_s = cap_r;
            ADDR_RISE_EN:      rd_field_s = rise_en_r;
            ADDR_FALL_EN:      rd_field_s = fall_en_r;
            default:           rd_field_s = '0;
        endcase
        rd_mux_s = '0;
        rd_mux_s[WIDTH-1:0] = rd_field_s;
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux_s;
        end
    end

    assign out_port = out_r;
    assign out_en   = dir_r;
    assign irq      = |(cap_r & mask_r);

endmodule

// File: tb/tb_pio_edge_irq_v2.sv
// Self-checking bench: dut0 has no debounce, dut1 debounces over 8 cycles
// and resets its output register to 0x5. Register reads go through a
// scoreboard queue of expected values.
module tb_pio_edge_irq_v2;
    import pio_v2_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs0, cs1;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
    logic [3:0]  in0, in1;
    logic [3:0]  out0, out1, oe0, oe1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pio_edge_irq_v2 #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_DIV(0), .RESET_OUT(32'h0)) dut0 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs0), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .irq(irq0),
        .in_port(in0), .out_port(out0), .out_en(oe0));

    pio_edge_irq_v2 #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_DIV(8), .RESET_OUT(32'h5)) dut1 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs1), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1),
        .in_port(in1), .out_port(out1), .out_en(oe1));

    task automatic bus_write(input int which, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs0 = (which == 0); cs1 = (which == 1);
        address = a; writedata = d; write_n = 1'b0;
        @(negedge clk);
        cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic bus_read(input int which, input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = (which == 1) ? rd1 : rd0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back((a == 6 || a == 7) ? 32'hF : 32'h0);
            bus_read(0, 3'(a), d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL reset_read addr %0d: got %h expected %h", a, d, e); end
        end
        n_checks++;
        if (out0 !== 4'h0) begin n_fail++; $display("FAIL reset_out0: got %h expected 0", out0); end
        n_checks++;
        if (out1 !== 4'h5) begin n_fail++; $display("FAIL reset_out1: got %h expected 5", out1); end
        n_checks++;
        if (oe0 !== 4'h0) begin n_fail++; $display("FAIL reset_oe0: got %h expected 0", oe0); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq0: got %b expected 0", irq0); end
    endtask

    task automatic test_outputs();
        logic [31:0] d, e;
        bus_write(0, ADDR_DATA, 32'hA);
        n_checks++;
        if (out0 !== 4'hA) begin n_fail++; $display("FAIL data_write: got %h expected a", out0); end
        bus_write(0, ADDR_OUTSET, 32'h1);
        n_checks++;
        if (out0 !== 4'hB) begin n_fail++; $display("FAIL outset: got %h expected b", out0); end
        bus_write(0, ADDR_OUTCLEAR, 32'h8);
        n_checks++;
        if (out0 !== 4'h3) begin n_fail++; $display("FAIL outclear: got %h expected 3", out0); end
        bus_write(0, ADDR_DIRECTION, 32'hFFFF_FFF3);
        n_checks++;
        if (oe0 !== 4'h3) begin n_fail++; $display("FAIL direction_oe: got %h expected 3", oe0); end
        exp_q.push_back(32'h3);
        bus_read(0, ADDR_DIRECTION, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL direction_read: got %h expected %h", d, e); end
    endtask

    task automatic test_rise_latency();
        logic [31:0] d, e;
        bus_write(0, ADDR_IRQ_MASK, 32'h1);
        bus_write(0, ADDR_RISE_EN, 32'h1);
        bus_write(0, ADDR_FALL_EN, 32'h0);
        @(negedge clk);
        in0[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_edge3: got %b expected 0", irq0); end
        @(posedge clk);
        #1;
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_edge4: got %b expected 1", irq0); end
        exp_q.push_back(32'h1);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL rise_capture: got %h expected %h", d, e); end
        bus_write(0, ADDR_EDGE_CAPTURE, 32'h1);
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq0); end
        in0[0] = 1'b0;
        wait_cycles(8);
        exp_q.push_back(32'h0);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL fall_disabled: got %h expected %h", d, e); end
    endtask

    task automatic test_capture_clear();
        logic [31:0] d, e;
        bus_write(0, ADDR_RISE_EN, 32'hF);
        in0 = 4'b0101;
        wait_cycles(8);
        exp_q.push_back(32'h5);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL capture_two_bits: got %h expected %h", d, e); end
        bus_write(0, ADDR_EDGE_CAPTURE, 32'h1);
        exp_q.push_back(32'h4);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL w1c_bit0: got %h expected %h", d, e); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked_bit2: got %b expected 0", irq0); end
        in0[2] = 1'b0;
        wait_cycles(8);
        bus_write(0, ADDR_EDGE_CAPTURE, 32'hF);
        exp_q.push_back(32'h0);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL w1c_all: got %h expected %h", d, e); end
        // New bit-2 edge lands at the same clock edge as a clear of bit 2.
        @(negedge clk);
        in0[2] = 1'b1;
        repeat (3) @(posedge clk);
        bus_write(0, ADDR_EDGE_CAPTURE, 32'h4);
        exp_q.push_back(32'h4);
        bus_read(0, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL set_beats_clear: got %h expected %h", d, e); end
    endtask

    task automatic test_debounce();
        logic [31:0] d, e;
        @(negedge clk);
        in1[1] = 1'b1;
        wait_cycles(7);
        in1[1] = 1'b0;
        wait_cycles(30);
        exp_q.push_back(32'h0);
        bus_read(1, ADDR_DATA, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL short_pulse_data: got %h expected %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(1, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL short_pulse_capture: got %h expected %h", d, e); end
        in1[1] = 1'b1;
        wait_cycles(40);
        exp_q.push_back(32'h2);
        bus_read(1, ADDR_DATA, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL long_pulse_data: got %h expected %h", d, e); end
        exp_q.push_back(32'h2);
        bus_read(1, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL long_pulse_capture: got %h expected %h", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        bus_write(1, ADDR_IRQ_MASK, 32'h2);
        bus_write(1, ADDR_DIRECTION, 32'h3);
        bus_write(1, ADDR_DATA, 32'hC);
        n_checks++;
        if (irq1 !== 1'b1) begin n_fail++; $display("FAIL irq_before_reset: got %b expected 1", irq1); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL async_irq_drop: got %b expected 0", irq1); end
        n_checks++;
        if (out1 !== 4'h5 || oe1 !== 4'h0) begin
            n_fail++; $display("FAIL async_out_reset: got out %h en %h expected out 5 en 0", out1, oe1);
        end
        n_checks++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL async_readdata: got %h expected 0", rd1); end
        wait_cycles(3);
        reset_n = 1'b1;
        exp_q.push_back(32'h0);
        bus_read(1, ADDR_IRQ_MASK, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL mask_after_reset: got %h expected %h", d, e); end
        exp_q.push_back(32'hF);
        bus_read(1, ADDR_RISE_EN, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL rise_en_after_reset: got %h expected %h", d, e); end
        wait_cycles(40);
        exp_q.push_back(32'h2);
        bus_read(1, ADDR_EDGE_CAPTURE, d);
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL capture_after_release: got %h expected %h", d, e); end
        n_checks++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL irq_masked_after_release: got %b expected 0", irq1); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; address = 3'd0;
        write_n = 1'b1; writedata = 32'h0; in0 = 4'h0; in1 = 4'h0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        test_reset();
        test_outputs();
        test_rise_latency();
        test_capture_clear();
        test_debounce();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
